cella_array_ctrl: RTL

Two-requester command controller for the CELLA 16-bank storage/search array. It arbitrates round-robin between two command sources and drives the array's op_code/addr/data_bank/data_in bus for a fixed hold window. It samples the array result and returns a tagged response over a valid/ready channel. It sits between host-side command generators and the array macro and is the only master of the array bus.

---
 rtl/cella_array_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cella_array_ctrl.sv
// rtl/cella_array_ctrl.sv - two-requester round-robin command controller for the CELLA array
module cella_array_ctrl #(
  parameter int ARR_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [8:0]       req0_addr,
  input  logic [15:0]      req0_data_bank,
  input  logic [15:0]      req0_data_in,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [8:0]       req1_addr,
  input  logic [15:0]      req1_data_bank,
  input  logic [15:0]      req1_data_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic             resp_err,
  output logic [15:0]      resp_data,
  output logic [1:0]       arr_op_code,
  output logic [8:0]       arr_addr,
  output logic [15:0]      arr_data_bank,
  output logic [15:0]      arr_data_in,
  input  logic [15:0]      arr_data_out,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int LW = (ARR_LAT < 2) ? 1 : $clog2(ARR_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic            rr_ptr;
  logic            cmd_id;
  logic [LW-1:0]   lat_cnt;

  logic            any_valid;
  logic            grant;
  logic [1:0]      g_op;
  logic [8:0]      g_addr;
  logic [15:0]     g_data_bank;
  logic [15:0]     g_data_in;
  logic            g_err;

  // Pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    g_op        = grant ? req1_op        : req0_op;
    g_addr      = grant ? req1_addr      : req0_addr;
    g_data_bank = grant ? req1_data_bank : req0_data_bank;
    g_data_in   = grant ? req1_data_in   : req0_data_in;
    g_err       = (g_op == 2'b11) || g_addr[8];
  end

  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid && grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      cmd_id        <= 1'b0;
      lat_cnt       <= '0;
      cmd_count     <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_err      <= 1'b0;
      resp_data     <= 16'h0000;
      arr_op_code   <= 2'b11;
      arr_addr      <= 9'h000;
      arr_data_bank <= 16'h0000;
      arr_data_in   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            cmd_id <= grant;
            rr_ptr <= ~grant;
            if (cmd_count != {CNT_W{1'b1}}) cmd_count <= cmd_count + 1'b1;
            if (g_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_id    <= grant;
              resp_err   <= 1'b1;
              resp_data  <= 16'h0000;
            end else begin
              state         <= ISSUE;
              lat_cnt       <= LW'(1);
              arr_op_code   <= g_op;
              arr_addr      <= g_addr;
              arr_data_bank <= g_data_bank;
              arr_data_in   <= g_data_in;
            end
          end
        end
        ISSUE: begin
          if (lat_cnt == LW'(ARR_LAT)) begin
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_id       <= cmd_id;
            resp_err      <= 1'b0;
            // The op still sits on the bus, so it tells us whether this was a write.
            resp_data     <= (arr_op_code == 2'b01) ? 16'h0000 : arr_data_out;
            arr_op_code   <= 2'b11;
            arr_addr      <= 9'h000;
            arr_data_bank <= 16'h0000;
            arr_data_in   <= 16'h0000;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
